// File: rtl/alarm_pkg.sv
// Shared constants and types for the alarm input conditioner and the alarm FSM it feeds.
package alarm_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 3;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int ZONE_COUNT          = 3;
  localparam int CNT_W               = 4;

  localparam logic KEY_IDLE  = 1'b1;
  localparam logic ZONE_IDLE = 1'b0;

  // State encoding of the downstream alarm controller FSM.
  typedef enum logic [1:0] {
    FSM_DISARMED = 2'd0,
    FSM_ARMING   = 2'd1,
    FSM_ARMED    = 2'd2,
    FSM_ALARM    = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain followed by a counter debouncer.
// dout is the debounced value as it will be after the coming edge; rise flags leaving IDLE_VAL.
module debounce_channel
  import alarm_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter logic IDLE_VAL        = 1'b0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q, d_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
      d_q    <= IDLE_VAL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      d_q    <= d_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    d_d   = d_q;
    cnt_d = '0;
    if (s != d_q) begin
      if (cnt_q == CNT_LAST) begin
        d_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dout = d_d;
  assign rise = (d_q == IDLE_VAL) && (d_d != IDLE_VAL);

endmodule

// File: rtl/alarm_input_conditioner.sv
// Conditions raw alarm panel inputs: debounced zone levels, key held levels and
// single-cycle key press pulses with panic taking priority over arm.
module alarm_input_conditioner
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iKEY_PANIC_N,
  input  logic                  iKEY_ARM_N,
  input  logic [ZONE_COUNT-1:0] iZONE,
  output logic                  panic_key,
  output logic                  arm_key,
  output logic [ZONE_COUNT-1:0] zone_sensor,
  output logic [1:0]            key_held
);

  logic                  panic_dout, panic_rise;
  logic                  arm_dout, arm_rise;
  logic [ZONE_COUNT-1:0] zone_dout;

  logic                  panic_key_q, panic_key_d;
  logic                  arm_key_q, arm_key_d;
  logic [ZONE_COUNT-1:0] zone_q;
  logic [1:0]            held_q, held_d;

  // Keys are debounced in the raw active-low domain; inversion happens on the way out.
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(KEY_IDLE)
  ) u_panic (
    .iCLK(iCLK), .iRST(iRST), .din(iKEY_PANIC_N), .dout(panic_dout), .rise(panic_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(KEY_IDLE)
  ) u_arm (
    .iCLK(iCLK), .iRST(iRST), .din(iKEY_ARM_N), .dout(arm_dout), .rise(arm_rise)
  );

  generate
    for (genvar gi = 0; gi < ZONE_COUNT; gi++) begin : g_zone
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(ZONE_IDLE)
      ) u_zone (
        .iCLK(iCLK), .iRST(iRST), .din(iZONE[gi]), .dout(zone_dout[gi]), .rise()
      );
    end
  endgenerate

  always_comb begin
    held_d      = {~arm_dout, ~panic_dout};
    panic_key_d = panic_rise;
    arm_key_d   = arm_rise & ~panic_rise & ~held_d[0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      panic_key_q <= 1'b0;
      arm_key_q   <= 1'b0;
      zone_q      <= '0;
      held_q      <= 2'b00;
    end else begin
      panic_key_q <= panic_key_d;
      arm_key_q   <= arm_key_d;
      zone_q      <= zone_dout;
      held_q      <= held_d;
    end
  end

  assign panic_key   = panic_key_q;
  assign arm_key     = arm_key_q;
  assign zone_sensor = zone_q;
  assign key_held    = held_q;

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Scenario bench for alarm_input_conditioner: expected outputs per edge are queued as
// stimulus is driven and compared after that edge.
module tb_alarm_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       panic_n, arm_n;
  logic [2:0] zone;
  logic       panic_key, arm_key;
  logic [2:0] zone_sensor;
  logic [1:0] key_held;

  typedef struct packed {
    logic       panic;
    logic       arm;
    logic [2:0] zone;
    logic [1:0] held;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  alarm_input_conditioner dut (
    .iCLK(clk), .iRST(rst), .iKEY_PANIC_N(panic_n), .iKEY_ARM_N(arm_n), .iZONE(zone),
    .panic_key(panic_key), .arm_key(arm_key), .zone_sensor(zone_sensor), .key_held(key_held)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; panic_n = 1'b1; arm_n = 1'b1; zone = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t ex, act;
    for (int e = 1; e <= 12; e++) begin
      if (e <= 3) begin
        rst = 1'b1; panic_n = 1'($urandom); arm_n = 1'($urandom); zone = 3'($urandom);
      end else begin
        rst = 1'b0; panic_n = 1'b1; arm_n = 1'b1; zone = 3'b000;
      end
      exp_q.push_back('0);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL reset e=%0d: got %b, expected %b", e, act, ex);
      end
    end
  endtask

  task automatic test_arm_press();
    exp_t ex, act;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      arm_n = (e >= 10 && e < 30) ? 1'b0 : 1'b1;
      ex = '0;
      ex.arm     = (e == 14);
      ex.held[1] = (e >= 14 && e < 34);
      exp_q.push_back(ex);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL arm_press e=%0d: got %b, expected %b", e, act, ex);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t ex, act;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      if (e >= 10 && e <= 13) arm_n = e[0];
      else                    arm_n = (e >= 14 && e < 30) ? 1'b0 : 1'b1;
      ex = '0;
      ex.arm     = (e == 18);
      ex.held[1] = (e >= 18 && e < 34);
      exp_q.push_back(ex);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL bounce e=%0d: got %b, expected %b", e, act, ex);
      end
    end
  endtask

  task automatic test_priority();
    exp_t ex, act;
    do_reset();
    for (int e = 1; e <= 75; e++) begin
      panic_n = ((e >= 5 && e < 15) || (e >= 25 && e < 45)) ? 1'b0 : 1'b1;
      arm_n   = ((e >= 5 && e < 15) || (e >= 35 && e < 50) || (e >= 60 && e < 68)) ? 1'b0 : 1'b1;
      ex = '0;
      ex.panic   = (e == 9) || (e == 29);
      ex.arm     = (e == 64);
      ex.held[0] = (e >= 9 && e < 19) || (e >= 29 && e < 49);
      ex.held[1] = (e >= 9 && e < 19) || (e >= 39 && e < 54) || (e >= 64 && e < 72);
      exp_q.push_back(ex);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL priority e=%0d: got %b, expected %b", e, act, ex);
      end
    end
  endtask

  task automatic test_zones();
    exp_t ex, act;
    do_reset();
    for (int e = 1; e <= 35; e++) begin
      zone    = (e >= 5 && e < 25) ? 3'b101 : 3'b000;
      zone[1] = (e == 10 || e == 11);
      panic_n = (e >= 5 && e < 25) ? 1'b0 : 1'b1;
      ex = '0;
      ex.zone    = (e >= 9 && e < 29) ? 3'b101 : 3'b000;
      ex.panic   = (e == 9);
      ex.held[0] = (e >= 9 && e < 29);
      exp_q.push_back(ex);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL zones e=%0d: got %b, expected %b", e, act, ex);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    exp_t ex, act;
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      arm_n = (e >= 1 && e < 15) ? 1'b0 : 1'b1;
      rst   = (e == 3);
      ex = '0;
      ex.arm     = (e == 8);
      ex.held[1] = (e >= 8 && e < 19);
      exp_q.push_back(ex);
      tick();
      ex  = exp_q.pop_front();
      act = {panic_key, arm_key, zone_sensor, key_held};
      tests_run++;
      if (act !== ex) begin
        tests_failed++;
        $display("FAIL reset_mid_debounce e=%0d: got %b, expected %b", e, act, ex);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; panic_n = 1'b1; arm_n = 1'b1; zone = 3'b000;
    test_reset();
    test_arm_press();
    test_bounce();
    test_priority();
    test_zones();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
